// File: rtl/wb_cmd_master.sv
// Wishbone classic single-word initiator: turns valid/ready commands into one
// read or write bus cycle, with a strobe timeout that returns an error response.
module wb_cmd_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // Ready is registered from the state, so it rises one cycle after
        // entering IDLE; this gives the bubble between back-to-back commands.
        if (cmd_valid && cmd_ready_q) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table-driven directed commands, hand-written corner
// sequences and randomized commands checked against a rule-level model.
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'd0;

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issues one command; the slave acks on strobe cycle ack_at (0 = never),
  // and the consumer stalls bp cycles before taking the response.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                        input int bp, output int strobes, output logic [31:0] rd,
                        output logic err);
    int   guard;
    logic bus_ok;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", 32'(guard < 50), 32'd1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_we = ~we;
    strobes = 0;
    bus_ok = 1'b1;
    while (wbm_cyc_o && strobes < 1000) begin
      strobes++;
      if (!wbm_stb_o || wbm_adr_o !== adr || wbm_we_o !== we || wbm_sel_o !== sel ||
          (we && wbm_dat_o !== dat) || cmd_ready)
        bus_ok = 1'b0;
      if (strobes == ack_at) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rdat;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
      end
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    chk("bus_fields_stable", 32'(bus_ok), 32'd1);
    chk("rsp_valid_set", 32'(rsp_valid), 32'd1);
    rd  = rsp_dat;
    err = rsp_err;
    for (int i = 0; i < bp; i++) begin
      wbm_ack_i = 1'(i & 1);
      @(negedge clk);
      wbm_ack_i = 1'b0;
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_dat_hold", rsp_dat, rd);
      chk("bp_no_ready_no_cyc", {30'd0, cmd_ready, wbm_cyc_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("bubble_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_bubble", 32'(cmd_ready), 32'd1);
    $display("[TB] txn %0d we=%0d adr=%h sel=%h ack_at=%0d strobes=%0d err=%0d dat=%h",
             txn, we, adr, sel, ack_at, strobes, err, rd);
    txn++;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] rdat;
    int          bp;
    int          exp_strobes;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          strobes, acc, ack_at, bp, exp_s;
    logic [31:0] rd, adr, dat, rdat, exp_d;
    logic        err, we, exp_e;
    logic [3:0]  sel;
    logic [31:0] hold_dat;

    vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_0F0F, 4'hF, 1, 32'hDEAD_BEEF, 0, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 32'h1234_5678, 0, 3, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 0, 32'h0,         0, 8, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'h3, 2, 32'h0,         5, 2, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 8, 32'hCAFE_F00D, 0, 8, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h3000_0044, 32'h0,         4'hF, 9, 32'h1111_2222, 1, 8, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h3000_0048, 32'h7777_8888, 4'hC, 0, 32'h0,         0, 8, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h3000_004C, 32'h0,         4'h3, 7, 32'h0F0F_1234, 2, 7, 1'b0, 32'h0F0F_1234};

    // Reset values while reset is held.
    #12;
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, cmd_ready}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat_o", wbm_dat_o, 32'd0);
    chk("rst_sel_we", {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_low_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    foreach (vecs[k]) begin
      do_cmd(vecs[k].we, vecs[k].adr, vecs[k].dat, vecs[k].sel, vecs[k].ack_at,
             vecs[k].rdat, vecs[k].bp, strobes, rd, err);
      chk($sformatf("vec%0d_strobes", k), 32'(strobes), 32'(vecs[k].exp_strobes));
      chk($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
      chk($sformatf("vec%0d_dat", k), rd, vecs[k].exp_dat);
    end

    // Stray ACK pulses while idle must not start anything or touch the response.
    hold_dat = rsp_dat;
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1'b1;
      wbm_dat_i = $urandom;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    chk("stray_no_cyc", {30'd0, wbm_cyc_o, rsp_valid}, 32'd0);
    chk("stray_ready", 32'(cmd_ready), 32'd1);
    chk("stray_rsp_dat", rsp_dat, hold_dat);

    // Back-to-back throughput with instant ACK and rsp_ready held high.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_0100;
    cmd_sel = 4'hF;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      wbm_ack_i = wbm_cyc_o;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wbm_ack_i = wbm_cyc_o;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("throughput_accepts", 32'(acc), 32'd5);
    $display("[TB] throughput: %0d commands accepted in 20 cycles", acc);

    // Asynchronous reset in the middle of a strobe.
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_0200;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_cyc", 32'(wbm_cyc_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("midrst_rsp_ready", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] mid-cycle reset applied");
    do_cmd(1'b0, 32'h3000_0204, 32'h0, 4'hF, 2, 32'h89AB_CDEF, 0, strobes, rd, err);
    chk("postrst_strobes", 32'(strobes), 32'd2);
    chk("postrst_dat", rd, 32'h89AB_CDEF);
    chk("postrst_err", 32'(err), 32'd0);

    // Randomized commands against the rule-level model.
    for (int n = 0; n < 40; n++) begin
      we     = 1'($urandom);
      adr    = $urandom;
      dat    = $urandom;
      sel    = 4'($urandom);
      rdat   = $urandom;
      ack_at = $urandom_range(0, TO + 2);
      bp     = $urandom_range(0, 3);
      if (ack_at >= 1 && ack_at <= TO) begin
        exp_s = ack_at;
        exp_e = 1'b0;
        exp_d = we ? 32'd0 : rdat;
      end else begin
        exp_s = TO;
        exp_e = 1'b1;
        exp_d = 32'd0;
      end
      do_cmd(we, adr, dat, sel, ack_at, rdat, bp, strobes, rd, err);
      chk("rand_strobes", 32'(strobes), 32'(exp_s));
      chk("rand_err", 32'(err), 32'(exp_e));
      chk("rand_dat", rd, exp_d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

endmodule
